load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the MEM-stage request (addr/data from EX) and the word-addressed
//  Data_Memory (async read, sync write on clk when WE=1). Converts RV32I
//  LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses: sign/zero-extends load data and
//  performs read-modify-write for sub-word stores. Multi-cycle FSM, valid/ready in.
// PARAMETERS
//  MEM_AW   5   word-address bits driven to memory (32 words); upper bits of mem_addr = 0
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst_n       in   1   synchronous reset, active low
//  req_valid   in   1   request present
//  req_ready   out  1   unit can accept request this cycle
//  req_we      in   1   1 = store, 0 = load
//  req_funct3  in   3   RV32I funct3 of the load/store
//  req_addr    in   32  byte address (rs1 + imm)
//  req_wdata   in   32  store data (rs2)
//  mem_addr    out  32  word address to Data_Memory: {0, addr_q[MEM_AW+1:2]}
//  mem_wd      out  32  write data to Data_Memory
//  mem_we      out  1   write enable to Data_Memory
//  mem_rdata   in   32  Data_Memory read data (combinational on mem_addr)
//  rsp_valid   out  1   one-cycle pulse: access complete
//  rsp_rdata   out  32  extended load result (0 for stores/errors)
//  rsp_err     out  1   illegal funct3 or misaligned (see CONFIGURATION)
// BEHAVIOUR
//  States: IDLE, RD, WR, RESP. Handshake: transfer when req_valid && req_ready;
//   req_ready = (state==IDLE). Request fields captured into *_q on transfer.
//  IDLE->RD for loads and SB/SH; IDLE->WR for SW; IDLE->RESP on error (no mem access).
//  RD: mem_addr from addr_q; mem_rdata latched at edge. Load -> RESP; SB/SH -> WR.
//  WR: mem_we=1 for exactly one cycle; mem_wd = SW: wdata_q;
//   SH: old word with half addr_q[1] replaced by wdata_q[15:0];
//   SB: old word with byte addr_q[1:0] replaced by wdata_q[7:0]. -> RESP.
//  RESP: rsp_valid=1 one cycle -> IDLE. No back-pressure on response.
//  Latency (accept edge to rsp_valid cycle): load 2, SW 2, SB/SH 3, error 1.
//  Load extract: byte = rdata>>(8*addr[1:0]), half = rdata>>(16*addr[1]);
//   LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
//  Legal funct3: loads 000,001,010,100,101; stores 000,001,010; else rsp_err=1.
//  Address wrap: byte-addr bits above MEM_AW+1 ignored (aliasing, no error).
//  mem_we = (state==WR) && rst_n: no write in any cycle with reset asserted.
//  mem_wd, mem_addr hold last value outside WR/RD; only mem_we qualifies a write.
//  Reset (rst_n=0 at edge): state=IDLE, *_q=0, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, mem_we=0, mem_addr=0, mem_wd=0; in-flight op dropped, no response.
//  req_valid while busy: ignored (req_ready=0); requester must hold it.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0
//   -> rsp_err=1, rsp_rdata=0, no memory read or write, latency 1.
//  Not defined: misalignment ignored; offset forced to natural alignment
//   (half: addr[0] treated 0; word: addr[1:0] treated 0); rsp_err only for funct3.
// TESTING
//  Reset, SW addr=0x08 wdata=0xDEADBEEF -> mem_we 1 cycle, mem_addr=2, rsp_valid 2 cycles after accept.
//  Mem[2]=0xDEADBEEF; LB 0x0B -> rsp_rdata=0xFFFFFFDE; LBU 0x0B -> 0x000000DE; LH 0x0A -> 0xFFFFDEAD.
//  Mem[2]=0xDEADBEEF; SB 0x09 wdata=0x12 -> Mem[2]=0xDEAD12EF, rsp 3 cycles; SH 0x0A 0x5678 -> 0x567812EF.
//  LW 0x06: with LSU_MISALIGN_TRAP_EN rsp_err=1, mem_we never set; without, reads Mem[1].
//  funct3=011 load -> rsp_err=1 after 1 cycle; rst_n=0 during SB's RD -> no write, no rsp_valid, IDLE.
//  Back-to-back: req_valid held high 3 requests -> req_ready low while busy, each accepted once, in order.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//    Bridges a MEM-stage load/store request to a word-addressed data memory
//    (asynchronous read, synchronous write). RV32I byte and halfword loads are
//    extracted from the word and sign/zero-extended. Byte and halfword stores
//    are done as read-modify-write. Word stores write directly.
//
// Parameters:
//    MEM_AW      number of word-address bits driven to memory
//
// Ports:
//    clk         system clock, all state on rising edge
//    rst_n       synchronous reset, active low
//    req_valid   request present
//    req_ready   unit can accept a request (high only when idle)
//    req_we      1 = store, 0 = load
//    req_funct3  RV32I funct3 of the access
//    req_addr    byte address
//    req_wdata   store data
//    mem_addr    word address to memory, upper bits zero
//    mem_wd      write data to memory
//    mem_we      write enable to memory
//    mem_rdata   memory read data (combinational on mem_addr)
//    rsp_valid   one-cycle pulse when the access completes
//    rsp_rdata   extended load result (0 for stores and errors)
//    rsp_err     illegal funct3, or misaligned when trapping is enabled
//
// Configuration:
//    LSU_MISALIGN_TRAP_EN  when defined, a misaligned halfword or word access
//                          completes with rsp_err and touches no memory. When
//                          undefined, the low address bits are ignored for
//                          those sizes, so the access uses natural alignment.
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter int MEM_AW = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t            state;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [1:0]        addr_q;
   logic [15:0]       wdata_q;
   logic [MEM_AW-1:0] mem_word;

   logic funct3_bad;
   logic misalign;
   logic req_err;
   logic req_fire;

   // Byte-address bits above the memory window alias onto the same words.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

   // Places the byte or halfword lane into the old word. A halfword uses
   // only addr bit 1, which gives natural alignment when trapping is off.
   function automatic logic [31:0] merge_store(input logic is_byte,
                                               input logic [1:0] off,
                                               input logic [31:0] old_word,
                                               input logic [15:0] data);
      logic [31:0] w;
      w = old_word;
      if (is_byte)
         w[{off, 3'b000} +: 8] = data[7:0];
      else
         w[{off[1], 4'b0000} +: 16] = data;
      return w;
   endfunction

   // Selects the addressed lane and extends it. funct3[2] marks an unsigned load.
   function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [31:0] word);
      logic [31:0] shifted;
      logic [31:0] r;
      case (f3[1:0])
         2'b00: begin
            shifted = word >> {off, 3'b000};
            r = {{24{shifted[7] & ~f3[2]}}, shifted[7:0]};
         end
         2'b01: begin
            shifted = word >> {off[1], 4'b0000};
            r = {{16{shifted[15] & ~f3[2]}}, shifted[15:0]};
         end
         default: r = word;
      endcase
      return r;
   endfunction

   // A request is rejected at accept time when its funct3 has no meaning
   // for its direction. When trapping is enabled, a misaligned halfword or
   // word address is also rejected. Either way the request gets a single-cycle
   // error response and never reaches memory.
   always_comb begin
      funct3_bad = 1'b0;
      misalign   = 1'b0;
      if (req_we)
         funct3_bad = req_funct3[2] | (&req_funct3[1:0]);
      else
         funct3_bad = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) |
                      (req_funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
   end

   assign req_err   = funct3_bad | misalign;
   assign req_ready = (state == IDLE);
   assign req_fire  = req_valid && req_ready;
   assign mem_addr  = {{(32-MEM_AW){1'b0}}, mem_word};

   // The write strobe is gated by reset so a reset landing in the WR cycle
   // cannot corrupt memory.
   assign mem_we = (state == WR) && rst_n;

   // Main sequencer. mem_addr and mem_wd are registered and change only when
   // the next memory access is set up. Outside RD and WR they keep their last
   // value. Response outputs are registered on entry to RESP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         funct3_q  <= 3'b000;
         addr_q    <= 2'b00;
         wdata_q   <= 16'h0000;
         mem_word  <= '0;
         mem_wd    <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_fire) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr[1:0];
                  wdata_q  <= req_wdata[15:0];
                  if (req_err) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= 32'h0;
                     rsp_err   <= 1'b1;
                     state     <= RESP;
                  end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
                     mem_word <= req_addr[MEM_AW+1:2];
                     mem_wd   <= req_wdata;
                     state    <= WR;
                  end else begin
                     mem_word <= req_addr[MEM_AW+1:2];
                     state    <= RD;
                  end
               end
            end
            RD: begin
               if (we_q) begin
                  mem_wd <= merge_store(funct3_q[1:0] == 2'b00, addr_q,
                                        mem_rdata, wdata_q);
                  state  <= WR;
               end else begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= load_extract(funct3_q, addr_q, mem_rdata);
                  rsp_err   <= 1'b0;
                  state     <= RESP;
               end
            end
            WR: begin
               rsp_valid <= 1'b1;
               rsp_rdata <= 32'h0;
               rsp_err   <= 1'b0;
               state     <= RESP;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. It models the data memory as a
// word array. The reference keeps memory as a flat byte array and works out
// each access from its byte address, its size and the extension rules. This
// gives the expected result, the error flag, the latency and the number of
// write strobes.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int MEM_AW = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic [31:0] tb_mem [32];
   logic [31:0] init_words [32];
   logic        loading = 1'b1;
   logic [7:0]  ref_bytes [128];

   int checks = 0;
   int failures = 0;

   load_store_unit #(.MEM_AW(MEM_AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Data memory: combinational read, write on the rising edge. Initial
   // contents are loaded while the unit is held in reset.
   assign mem_rdata = tb_mem[mem_addr[4:0]];

   always @(posedge clk) begin
      if (loading) begin
         for (int w = 0; w < 32; w++) tb_mem[w] <= init_words[w];
      end else if (mem_we) begin
         tb_mem[mem_addr[4:0]] <= mem_wd;
      end
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // One comparison: counts it, and reports and counts a failure
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reassembles a word from the reference byte array
   function automatic logic [31:0] ref_word(input int idx);
      logic [31:0] w;
      w = 32'h0;
      for (int b = 0; b < 4; b++) w = w | (32'(ref_bytes[4*idx+b]) << (8*b));
      return w;
   endfunction

   // Reference behaviour of one access against the byte-array memory
   function automatic void ref_access(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic [31:0] rdata, output logic err,
                                     output int lat, output int writes);
      int          size;
      int          a;
      logic        legal;
      logic [31:0] val;
      legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size   = 1 << f3[1:0];
      err    = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
      if (legal && ((addr % size) != 0)) err = 1'b1;
`endif
      rdata  = 32'h0;
      writes = 0;
      lat    = 1;
      if (!err) begin
         a = int'(addr % 32'd128);
         a = a - (a % size);
         if (we) begin
            for (int i = 0; i < size; i++) ref_bytes[a+i] = wdata[8*i +: 8];
            writes = 1;
            lat    = (size == 4) ? 2 : 3;
         end else begin
            val = 32'h0;
            for (int i = 0; i < size; i++) val = val | (32'(ref_bytes[a+i]) << (8*i));
            if (!f3[2] && (size < 4) && val[8*size-1])
               val = val | (32'hFFFF_FFFF << (8*size));
            rdata = val;
            lat   = 2;
         end
      end
   endfunction

   // Issues one request from a falling edge with the unit idle. Then it watches
   // each cycle until the response, counting write strobes. It returns on the
   // falling edge after the response cycle.
   task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output int lat, output int we_cycles,
                                output logic [31:0] wr_addr,
                                output logic [31:0] rdata, output logic err);
      bit done;
      done = 1'b0;
      lat = 0; we_cycles = 0; wr_addr = 32'h0; rdata = 32'h0; err = 1'b0;
      checkOutput("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      while (!done && lat < 8) begin
         lat++;
         @(negedge clk);
         if (mem_we) begin
            we_cycles++;
            wr_addr = mem_addr;
         end
         if (rsp_valid) begin
            done  = 1'b1;
            rdata = rsp_rdata;
            err   = rsp_err;
         end else begin
            @(posedge clk);
         end
      end
      checkOutput("rsp_seen", 32'(done), 32'd1);
      @(negedge clk);
      checkOutput("rsp_pulse", 32'(rsp_valid), 32'd0);
   endtask

   // Runs one access and checks it against the reference
   task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output logic [31:0] wr_addr);
      int          we_cycles;
      int          exp_lat;
      int          exp_writes;
      logic [31:0] exp_rdata;
      logic        exp_err;
      applyStimulus(we, f3, addr, wdata, lat, we_cycles, wr_addr, rdata, err);
      ref_access(we, f3, addr, wdata, exp_rdata, exp_err, exp_lat, exp_writes);
      checkOutput({tag, "_rdata"}, rdata, exp_rdata);
      checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
      checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, "_writes"}, 32'(we_cycles), 32'(exp_writes));
   endtask

   // Directed steps followed by back-to-back and random traffic
   initial begin
      logic [31:0] rd;
      logic [31:0] wa;
      logic        er;
      int          lt;
      logic [31:0] exp_rd_q [$];
      logic        exp_er_q [$];
      logic        bw_we [3];
      logic [2:0]  bw_f3 [3];
      logic [31:0] bw_addr [3];
      logic [31:0] bw_wd [3];
      int          idx;
      int          nresp;
      bit          busy;
      bit          accept_next;
      logic [31:0] e_rd;
      logic        e_er;
      int          e_lat;
      int          e_wr;
      logic        r_we;
      logic [2:0]  r_f3;

      for (int w = 0; w < 32; w++) begin
         init_words[w] = $urandom;
         for (int b = 0; b < 4; b++) ref_bytes[4*w+b] = init_words[w][8*b +: 8];
      end

      // Reset state
      rst_n = 1'b0; loading = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_mem_wd", mem_wd, 32'h0);
      checkOutput("rst_ready", 32'(req_ready), 32'd1);
      rst_n = 1'b1; loading = 1'b0;

      // Word store, then sub-word loads of the same word
      run_op("sw08", 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, rd, er, lt, wa);
      checkOutput("sw08_latency", 32'(lt), 32'd2);
      checkOutput("sw08_addr", wa, 32'd2);
      checkOutput("sw08_mem", tb_mem[2], 32'hDEADBEEF);
      run_op("lb0b", 1'b0, 3'b000, 32'h0B, 32'h0, rd, er, lt, wa);
      checkOutput("lb0b_val", rd, 32'hFFFFFFDE);
      run_op("lbu0b", 1'b0, 3'b100, 32'h0B, 32'h0, rd, er, lt, wa);
      checkOutput("lbu0b_val", rd, 32'h000000DE);
      run_op("lh0a", 1'b0, 3'b001, 32'h0A, 32'h0, rd, er, lt, wa);
      checkOutput("lh0a_val", rd, 32'hFFFFDEAD);
      run_op("lhu0a", 1'b0, 3'b101, 32'h0A, 32'h0, rd, er, lt, wa);

      // Read-modify-write stores
      run_op("sb09", 1'b1, 3'b000, 32'h09, 32'h12, rd, er, lt, wa);
      checkOutput("sb09_latency", 32'(lt), 32'd3);
      checkOutput("sb09_mem", tb_mem[2], 32'hDEAD12EF);
      run_op("sh0a", 1'b1, 3'b001, 32'h0A, 32'h5678, rd, er, lt, wa);
      checkOutput("sh0a_mem", tb_mem[2], 32'h567812EF);

      // Address aliasing above the memory window
      run_op("lw188", 1'b0, 3'b010, 32'h188, 32'h0, rd, er, lt, wa);
      checkOutput("lw188_val", rd, 32'h567812EF);

      // Misaligned word load
      run_op("lw06", 1'b0, 3'b010, 32'h06, 32'h0, rd, er, lt, wa);
`ifdef LSU_MISALIGN_TRAP_EN
      checkOutput("lw06_trap", 32'(er), 32'd1);
`else
      checkOutput("lw06_word1", rd, init_words[1]);
`endif

      // Illegal funct3 for a load and for a store
      run_op("ld011", 1'b0, 3'b011, 32'h04, 32'h0, rd, er, lt, wa);
      checkOutput("ld011_err", 32'(er), 32'd1);
      checkOutput("ld011_latency", 32'(lt), 32'd1);
      run_op("st100", 1'b1, 3'b100, 32'h04, 32'hFFFF_FFFF, rd, er, lt, wa);

      // Reset during the read phase of a byte store
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h10; req_wdata = 32'hA5;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstrd_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rstrd_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rstrd_ready", 32'(req_ready), 32'd1);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("rstrd_no_rsp", 32'(rsp_valid), 32'd0);
      end
      checkOutput("rstrd_mem", tb_mem[4], ref_word(4));

      // Reset asserted during the write cycle must suppress the write
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
      req_addr = 32'h12; req_wdata = 32'hC3C3;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstwr_we_before", 32'(mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rstwr_we_gated", 32'(mem_we), 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstwr_ready", 32'(req_ready), 32'd1);
      checkOutput("rstwr_rsp_valid", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rstwr_mem", tb_mem[4], ref_word(4));

      // Back-to-back requests with req_valid held high
      bw_we[0] = 1'b0; bw_f3[0] = 3'b010; bw_addr[0] = 32'h08; bw_wd[0] = 32'h0;
      bw_we[1] = 1'b1; bw_f3[1] = 3'b000; bw_addr[1] = 32'h0D; bw_wd[1] = 32'h77;
      bw_we[2] = 1'b0; bw_f3[2] = 3'b100; bw_addr[2] = 32'h0D; bw_wd[2] = 32'h0;
      idx = 0; nresp = 0; busy = 1'b0;
      for (int cyc = 0; cyc < 40 && nresp < 3; cyc++) begin
         checkOutput("b2b_ready", 32'(req_ready), 32'(!busy));
         if (rsp_valid) begin
            if (exp_rd_q.size() > 0) begin
               e_rd = exp_rd_q.pop_front();
               e_er = exp_er_q.pop_front();
               checkOutput("b2b_rdata", rsp_rdata, e_rd);
               checkOutput("b2b_err", 32'(rsp_err), 32'(e_er));
            end else begin
               checkOutput("b2b_extra_rsp", 32'(rsp_valid), 32'd0);
            end
            nresp++;
            busy = 1'b0;
         end
         if (idx < 3) begin
            req_valid = 1'b1; req_we = bw_we[idx]; req_funct3 = bw_f3[idx];
            req_addr = bw_addr[idx]; req_wdata = bw_wd[idx];
         end else begin
            req_valid = 1'b0;
         end
         accept_next = req_valid && req_ready;
         @(posedge clk);
         #1;
         if (accept_next) begin
            ref_access(bw_we[idx], bw_f3[idx], bw_addr[idx], bw_wd[idx],
                       e_rd, e_er, e_lat, e_wr);
            exp_rd_q.push_back(e_rd);
            exp_er_q.push_back(e_er);
            idx++;
            busy = 1'b1;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      checkOutput("b2b_accepts", 32'(idx), 32'd3);
      checkOutput("b2b_responses", 32'(nresp), 32'd3);
      @(negedge clk);
      checkOutput("b2b_quiet", 32'(rsp_valid), 32'd0);

      // Random traffic over all funct3 codes and full 32-bit addresses
      for (int n = 0; n < 40; n++) begin
         r_we = 1'($urandom_range(0, 1));
         r_f3 = 3'($urandom_range(0, 7));
         run_op("rand", r_we, r_f3, $urandom, $urandom, rd, er, lt, wa);
      end

      // Final memory image against the reference
      for (int w = 0; w < 32; w++) checkOutput("final_mem", tb_mem[w], ref_word(w));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
